// File: rtl/stream_dedup_pkg.sv
// stream_dedup_pkg: shared definitions for the stream_dedup block.
//   - default width localparams for the data value and the run-length count
//   - stream_dedup_state_t: the dedup FSM states
// Optional feature macro used by the block: STREAM_DEDUP_COUNT_EN.
package stream_dedup_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_COUNT_WIDTH = 16;

   // EMPTY : nothing pending
   // HOLD  : a run value is pending in pend
   // FLUSH : upstream finished, pending run still to be emitted
   // DONE  : stream finished, waits for _start
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } stream_dedup_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry output register for the dedup stream.
// Holds _0 (and _1 when STREAM_DEDUP_COUNT_EN is defined) plus _valid.
//   load  : capture load_0/load_1 and raise _valid (wins over the drop)
//   else  : _valid drops on an output beat (_valid && ready)
//   clear : synchronous clear of all contents
// Ports:
//   _clock, clear, load, ready      in
//   load_0 [DATA_WIDTH]             in   value to capture
//   load_1 [COUNT_WIDTH]            in   run length (count build only)
//   _0, _1, _valid                  out  registered output slot
//   slot_free                       out  !_valid || ready
// Configuration macro: STREAM_DEDUP_COUNT_EN.
module stream_out_reg
   import stream_dedup_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef STREAM_DEDUP_COUNT_EN
   , parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
`endif
) (
   input  logic                         _clock,
   input  logic                         clear,
   input  logic                         load,
   input  logic                         ready,
   input  logic signed [DATA_WIDTH-1:0] load_0,
`ifdef STREAM_DEDUP_COUNT_EN
   input  logic [COUNT_WIDTH-1:0]       load_1,
   output logic [COUNT_WIDTH-1:0]       _1,
`endif
   output logic signed [DATA_WIDTH-1:0] _0,
   output logic                         _valid,
   output logic                         slot_free
);

   assign slot_free = !_valid || ready;

   always_ff @(posedge _clock) begin
      if (clear) begin
         _valid <= 1'b0;
         _0     <= '0;
`ifdef STREAM_DEDUP_COUNT_EN
         _1     <= '0;
`endif
      end else if (load) begin
         _valid <= 1'b1;
         _0     <= load_0;
`ifdef STREAM_DEDUP_COUNT_EN
         _1     <= load_1;
`endif
      end else if (_valid && ready) begin
         _valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_dedup.sv
// stream_dedup: collapses runs of consecutive equal values of a
// generator-style stream into one output value per run.
// Handshake: a beat happens on a posedge where valid && ready are both high;
// the producer holds its value stable until that beat, and the consumer's
// ready may change freely. _in_ready depends on _ready and state only.
// Ports:
//   _clock, _reset (sync, active high), _start (wins over _reset)   in
//   _in_0 [DATA_WIDTH], _in_valid, _in_done                      in  upstream
//   _in_ready                                                    out upstream
//   _ready                                                       in  downstream
//   _valid, _done, _0 [DATA_WIDTH], _1 [COUNT_WIDTH]             out downstream
//   _state                                                       out FSM state
// _1 and the run counter exist only when STREAM_DEDUP_COUNT_EN is defined.
module stream_dedup
   import stream_dedup_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef STREAM_DEDUP_COUNT_EN
   , parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
`endif
) (
   input  logic                         _clock,
   input  logic                         _reset,
   input  logic                         _start,
   input  logic signed [DATA_WIDTH-1:0] _in_0,
   input  logic                         _in_valid,
   input  logic                         _in_done,
   output logic                         _in_ready,
   input  logic                         _ready,
   output logic                         _valid,
   output logic                         _done,
   output logic signed [DATA_WIDTH-1:0] _0,
`ifdef STREAM_DEDUP_COUNT_EN
   output logic [COUNT_WIDTH-1:0]       _1,
`endif
   output logic [1:0]                   _state
);

   stream_dedup_state_t          state, state_n;
   logic signed [DATA_WIDTH-1:0] pend, pend_n;
`ifdef STREAM_DEDUP_COUNT_EN
   logic [COUNT_WIDTH-1:0]       cnt, cnt_n;
`endif
   logic load;
   logic slot_free;
   logic in_beat;
   logic done_take;
   logic valid_n;
   logic done_q;

   assign _in_ready = ((state == EMPTY) || (state == HOLD)) && slot_free;
   assign in_beat   = _in_valid && _in_ready;
   // A done flag that arrives with a value only counts once that value is taken.
   assign done_take = _in_done && (!_in_valid || _in_ready);
   // _valid as it will be after this edge
   assign valid_n   = load || (_valid && !_ready);
   assign _done     = done_q;
   assign _state    = state;

   always_comb begin
      state_n = state;
      pend_n  = pend;
`ifdef STREAM_DEDUP_COUNT_EN
      cnt_n   = cnt;
`endif
      load    = 1'b0;
      case (state)
         EMPTY: begin
            if (in_beat) begin
               pend_n  = _in_0;
`ifdef STREAM_DEDUP_COUNT_EN
               cnt_n   = COUNT_WIDTH'(1);
`endif
               state_n = done_take ? FLUSH : HOLD;
            end else if (done_take) begin
               state_n = DONE;
            end
         end
         HOLD: begin
            if (in_beat) begin
               if (_in_0 == pend) begin
`ifdef STREAM_DEDUP_COUNT_EN
                  if (cnt != '1) cnt_n = cnt + 1'b1;
`endif
               end else begin
                  // emit the finished run, start a new one
                  load   = 1'b1;
                  pend_n = _in_0;
`ifdef STREAM_DEDUP_COUNT_EN
                  cnt_n  = COUNT_WIDTH'(1);
`endif
               end
            end
            if (done_take) state_n = FLUSH;
         end
         FLUSH: begin
            if (slot_free) begin
               load    = 1'b1;
               state_n = DONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge _clock) begin
      if (_start) begin
         state  <= EMPTY;
         pend   <= '0;
`ifdef STREAM_DEDUP_COUNT_EN
         cnt    <= '0;
`endif
         done_q <= 1'b0;
      end else if (_reset) begin
         state  <= DONE;
         pend   <= '0;
`ifdef STREAM_DEDUP_COUNT_EN
         cnt    <= '0;
`endif
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         pend   <= pend_n;
`ifdef STREAM_DEDUP_COUNT_EN
         cnt    <= cnt_n;
`endif
         // done only once the final value has left the output slot
         done_q <= (state_n == DONE) && !valid_n;
      end
   end

   stream_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef STREAM_DEDUP_COUNT_EN
      , .COUNT_WIDTH(COUNT_WIDTH)
`endif
   ) u_out (
      ._clock    (_clock),
      .clear     (_start || _reset),
      .load      (load),
      .ready     (_ready),
      .load_0    (pend),
`ifdef STREAM_DEDUP_COUNT_EN
      .load_1    (cnt),
      ._1        (_1),
`endif
      ._0        (_0),
      ._valid    (_valid),
      .slot_free (slot_free)
   );

endmodule
